ili9341_8080_i_receiver: RTL and testbench

ILI9341_8080_I_RECEIVER -- requirements
Module: ili9341_8080_i_receiver

---
 rtl/ili9341_8080_i_receiver.sv | 252 +++++++++++++++++++++++++
 tb/tb_ili9341_8080_i_receiver.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ili9341_8080_i_receiver.sv
// ILI9341 8080-I write-only bus receiver: synchronizes the host bus, decodes
// CASET/PASET/RAMWR and streams RGB565 pixels with linear frame addresses.
module ili9341_8080_i_receiver #(
  parameter int NUM_COLS = 240,
  parameter int NUM_ROWS = 320
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  tftParallelPort,
  input  logic        tftChipSelect,
  input  logic        tftWriteEnable,
  input  logic        tftDataCmd,
  input  logic        tftReset,
  output logic        cmdStrobe,
  output logic [7:0]  cmdByte,
  output logic        paramStrobe,
  output logic [7:0]  paramByte,
  output logic [6:0]  paramIndex,
  output logic        pixelWrEn,
  output logic [16:0] pixelAddr,
  output logic [15:0] pixelData,
  output logic        frameDone
);
  typedef enum logic [2:0] {IDLE, CASET, PASET, RAMWR, OTHER} state_e;

  localparam logic [15:0] COL_LIM = 16'(NUM_COLS);
  localparam logic [15:0] ROW_LIM = 16'(NUM_ROWS);
  localparam logic [16:0] COLS17  = 17'(NUM_COLS);
  localparam logic [15:0] EC_RST  = 16'(NUM_COLS - 1);
  localparam logic [15:0] EP_RST  = 16'(NUM_ROWS - 1);

  // Bus synchronizers; index [1] is the stage the decoder consumes
  logic [1:0]      cs_q, cs_d, dc_q, dc_d, hrst_q, hrst_d;
  logic [2:0]      wr_q, wr_d;
  logic [1:0][7:0] dat_q, dat_d;

  // Accepted-byte register between edge detection and decode
  logic       acc_q, acc_d, acc_dc_q, acc_dc_d;
  logic [7:0] acc_byte_q, acc_byte_d;

  state_e      state_q, state_d;
  logic [15:0] sc_q, sc_d, ec_q, ec_d, sp_q, sp_d, ep_q, ep_d;
  logic [15:0] col_q, col_d, page_q, page_d;
  logic        hi_pend_q, hi_pend_d;
  logic [7:0]  hi_q, hi_d;
  logic [23:0] tmp_q, tmp_d;
  logic [6:0]  cnt_q, cnt_d;
  logic        cmd_stb_q, cmd_stb_d, par_stb_q, par_stb_d;
  logic        pix_we_q, pix_we_d, frame_q, frame_d;
  logic [7:0]  cmd_byte_q, cmd_byte_d, par_byte_q, par_byte_d;
  logic [6:0]  par_idx_q, par_idx_d;
  logic [16:0] pix_addr_q, pix_addr_d;
  logic [15:0] pix_data_q, pix_data_d;

  logic [15:0] win_lo, win_hi;
  logic [16:0] cur_addr;

  assign win_lo   = tmp_q[23:8];
  assign win_hi   = {tmp_q[7:0], acc_byte_q};
  assign cur_addr = {1'b0, page_q} * COLS17 + {1'b0, col_q};

  always_comb begin
    cs_d       = {cs_q[0], tftChipSelect};
    dc_d       = {dc_q[0], tftDataCmd};
    hrst_d     = {hrst_q[0], tftReset};
    wr_d       = {wr_q[1:0], tftWriteEnable};
    dat_d      = {dat_q[0], tftParallelPort};
    acc_d      = wr_q[1] & ~wr_q[2] & ~cs_q[1] & hrst_q[1];
    acc_dc_d   = dc_q[1];
    acc_byte_d = dat_q[1];
  end

  always_comb begin
    state_d    = state_q;
    sc_d       = sc_q;
    ec_d       = ec_q;
    sp_d       = sp_q;
    ep_d       = ep_q;
    col_d      = col_q;
    page_d     = page_q;
    hi_pend_d  = hi_pend_q;
    hi_d       = hi_q;
    tmp_d      = tmp_q;
    cnt_d      = cnt_q;
    cmd_byte_d = cmd_byte_q;
    par_byte_d = par_byte_q;
    par_idx_d  = par_idx_q;
    pix_addr_d = pix_addr_q;
    pix_data_d = pix_data_q;
    cmd_stb_d  = 1'b0;
    par_stb_d  = 1'b0;
    pix_we_d   = 1'b0;
    frame_d    = 1'b0;
    if (!hrst_q[1]) begin
      state_d    = IDLE;
      sc_d       = '0;
      ec_d       = EC_RST;
      sp_d       = '0;
      ep_d       = EP_RST;
      col_d      = '0;
      page_d     = '0;
      hi_pend_d  = 1'b0;
      hi_d       = '0;
      tmp_d      = '0;
      cnt_d      = '0;
      cmd_byte_d = '0;
      par_byte_d = '0;
      par_idx_d  = '0;
      pix_addr_d = '0;
      pix_data_d = '0;
    end else begin
      // Deselecting the chip drops a half-received pixel only
      if (cs_q[1]) hi_pend_d = 1'b0;
      if (acc_q && !acc_dc_q) begin
        cmd_stb_d  = 1'b1;
        cmd_byte_d = acc_byte_q;
        cnt_d      = '0;
        par_idx_d  = '0;
        hi_pend_d  = 1'b0;
        case (acc_byte_q)
          8'h2A: state_d = CASET;
          8'h2B: state_d = PASET;
          8'h2C: begin
            state_d = RAMWR;
            col_d   = sc_q;
            page_d  = sp_q;
          end
          8'h3C: state_d = RAMWR;
          default: state_d = OTHER;
        endcase
      end else if (acc_q) begin
        case (state_q)
          CASET, PASET, OTHER: begin
            par_stb_d  = 1'b1;
            par_byte_d = acc_byte_q;
            par_idx_d  = cnt_q;
            cnt_d      = (cnt_q == 7'd127) ? cnt_q : cnt_q + 7'd1;
            if (state_q != OTHER) begin
              case (cnt_q)
                7'd0: tmp_d[23:16] = acc_byte_q;
                7'd1: tmp_d[15:8]  = acc_byte_q;
                7'd2: tmp_d[7:0]   = acc_byte_q;
                7'd3: begin
                  // Window committed only when start<=end<limit
                  if (state_q == CASET && win_lo <= win_hi && win_hi < COL_LIM) begin
                    sc_d = win_lo;
                    ec_d = win_hi;
                  end else if (state_q == PASET && win_lo <= win_hi && win_hi < ROW_LIM) begin
                    sp_d = win_lo;
                    ep_d = win_hi;
                  end
                end
                default: ;
              endcase
            end
          end
          RAMWR: begin
            if (!hi_pend_q) begin
              hi_d      = acc_byte_q;
              hi_pend_d = 1'b1;
            end else begin
              hi_pend_d  = 1'b0;
              pix_we_d   = 1'b1;
              pix_data_d = {hi_q, acc_byte_q};
              pix_addr_d = cur_addr;
              frame_d    = (col_q == ec_q) && (page_q == ep_q);
              if (col_q == ec_q) begin
                col_d  = sc_q;
                page_d = (page_q == ep_q) ? sp_q : page_q + 16'd1;
              end else begin
                col_d = col_q + 16'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cs_q       <= 2'b11;
      dc_q       <= '0;
      hrst_q     <= 2'b11;
      wr_q       <= 3'b111;
      dat_q      <= '0;
      acc_q      <= 1'b0;
      acc_dc_q   <= 1'b0;
      acc_byte_q <= '0;
      state_q    <= IDLE;
      sc_q       <= '0;
      ec_q       <= EC_RST;
      sp_q       <= '0;
      ep_q       <= EP_RST;
      col_q      <= '0;
      page_q     <= '0;
      hi_pend_q  <= 1'b0;
      hi_q       <= '0;
      tmp_q      <= '0;
      cnt_q      <= '0;
      cmd_stb_q  <= 1'b0;
      par_stb_q  <= 1'b0;
      pix_we_q   <= 1'b0;
      frame_q    <= 1'b0;
      cmd_byte_q <= '0;
      par_byte_q <= '0;
      par_idx_q  <= '0;
      pix_addr_q <= '0;
      pix_data_q <= '0;
    end else begin
      cs_q       <= cs_d;
      dc_q       <= dc_d;
      hrst_q     <= hrst_d;
      wr_q       <= wr_d;
      dat_q      <= dat_d;
      acc_q      <= acc_d;
      acc_dc_q   <= acc_dc_d;
      acc_byte_q <= acc_byte_d;
      state_q    <= state_d;
      sc_q       <= sc_d;
      ec_q       <= ec_d;
      sp_q       <= sp_d;
      ep_q       <= ep_d;
      col_q      <= col_d;
      page_q     <= page_d;
      hi_pend_q  <= hi_pend_d;
      hi_q       <= hi_d;
      tmp_q      <= tmp_d;
      cnt_q      <= cnt_d;
      cmd_stb_q  <= cmd_stb_d;
      par_stb_q  <= par_stb_d;
      pix_we_q   <= pix_we_d;
      frame_q    <= frame_d;
      cmd_byte_q <= cmd_byte_d;
      par_byte_q <= par_byte_d;
      par_idx_q  <= par_idx_d;
      pix_addr_q <= pix_addr_d;
      pix_data_q <= pix_data_d;
    end
  end

  assign cmdStrobe   = cmd_stb_q;
  assign cmdByte     = cmd_byte_q;
  assign paramStrobe = par_stb_q;
  assign paramByte   = par_byte_q;
  assign paramIndex  = par_idx_q;
  assign pixelWrEn   = pix_we_q;
  assign pixelAddr   = pix_addr_q;
  assign pixelData   = pix_data_q;
  assign frameDone   = frame_q;
endmodule

// File: tb/tb_ili9341_8080_i_receiver.sv
// Randomized bench for the 8080-I receiver: a window/cursor reference model
// queues expected strobes; a negedge monitor pops and compares them.
module tb_ili9341_8080_i_receiver;
  localparam int NC = 240;
  localparam int NR = 320;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  tftParallelPort = '0;
  logic        tftChipSelect = 1'b1;
  logic        tftWriteEnable = 1'b1;
  logic        tftDataCmd = 1'b0;
  logic        tftReset = 1'b1;
  logic        cmdStrobe, paramStrobe, pixelWrEn, frameDone;
  logic [7:0]  cmdByte, paramByte;
  logic [6:0]  paramIndex;
  logic [16:0] pixelAddr;
  logic [15:0] pixelData;

  ili9341_8080_i_receiver #(.NUM_COLS(NC), .NUM_ROWS(NR)) dut (
    .clk(clk), .reset(reset), .tftParallelPort(tftParallelPort),
    .tftChipSelect(tftChipSelect), .tftWriteEnable(tftWriteEnable),
    .tftDataCmd(tftDataCmd), .tftReset(tftReset),
    .cmdStrobe(cmdStrobe), .cmdByte(cmdByte), .paramStrobe(paramStrobe),
    .paramByte(paramByte), .paramIndex(paramIndex), .pixelWrEn(pixelWrEn),
    .pixelAddr(pixelAddr), .pixelData(pixelData), .frameDone(frameDone)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;  // 0 command, 1 parameter, 2 pixel
    logic [7:0]  b;
    logic [6:0]  idx;
    logic [15:0] data;
    logic [16:0] addr;
    logic        fd;
  } ev_t;

  ev_t sb[$];
  ev_t e;
  int  checks = 0;
  int  errors = 0;

  // Reference model: display window, cursor and byte-phase state
  int m_mode;  // 0 idle, 1 column window, 2 page window, 3 memory write, 4 other
  int m_sc, m_ec, m_sp, m_ep, m_col, m_page, m_cnt, m_pend, m_hi;
  int m_buf[4];

  function automatic ev_t mk(input int k, input int b, input int idx, input int data,
                             input int addr, input int fd);
    ev_t r;
    r.kind = k; r.b = 8'(b); r.idx = 7'(idx); r.data = 16'(data);
    r.addr = 17'(addr); r.fd = 1'(fd);
    return r;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_sc = 0; m_ec = NC - 1; m_sp = 0; m_ep = NR - 1;
    m_col = 0; m_page = 0; m_cnt = 0; m_pend = 0; m_hi = 0;
    sb.delete();
  endtask

  task automatic model_byte(input bit dc, input int b);
    int s, en;
    if (!dc) begin
      sb.push_back(mk(0, b, 0, 0, 0, 0));
      m_cnt = 0; m_pend = 0;
      if (b == 'h2A) m_mode = 1;
      else if (b == 'h2B) m_mode = 2;
      else if (b == 'h2C) begin m_mode = 3; m_col = m_sc; m_page = m_sp; end
      else if (b == 'h3C) m_mode = 3;
      else m_mode = 4;
    end else if (m_mode == 1 || m_mode == 2 || m_mode == 4) begin
      sb.push_back(mk(1, b, (m_cnt > 127) ? 127 : m_cnt, 0, 0, 0));
      if (m_mode != 4 && m_cnt < 4) m_buf[m_cnt] = b;
      if (m_mode != 4 && m_cnt == 3) begin
        s  = m_buf[0] * 256 + m_buf[1];
        en = m_buf[2] * 256 + b;
        if (m_mode == 1 && s <= en && en < NC) begin m_sc = s; m_ec = en; end
        if (m_mode == 2 && s <= en && en < NR) begin m_sp = s; m_ep = en; end
      end
      m_cnt++;
    end else if (m_mode == 3) begin
      if (m_pend == 0) begin
        m_hi = b; m_pend = 1;
      end else begin
        m_pend = 0;
        sb.push_back(mk(2, 0, 0, m_hi * 256 + b, m_page * NC + m_col,
                        (m_col == m_ec && m_page == m_ep) ? 1 : 0));
        if (m_col == m_ec) begin
          m_col = m_sc;
          m_page = (m_page == m_ep) ? m_sp : m_page + 1;
        end else m_col++;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {4'h0, cmdStrobe, cmdByte, paramStrobe, paramByte, paramIndex,
            pixelWrEn, pixelAddr, pixelData, frameDone};
  endfunction

  task automatic write_byte(input bit dc, input int b);
    @(negedge clk);
    tftDataCmd = dc; tftParallelPort = 8'(b); tftChipSelect = 1'b0; tftWriteEnable = 1'b0;
    repeat (3) @(negedge clk);
    tftWriteEnable = 1'b1;
    if (tftReset) model_byte(dc, b);
    repeat (5) @(negedge clk);
  endtask

  task automatic cs_toggle();
    @(negedge clk);
    tftChipSelect = 1'b1;
    repeat (4) @(negedge clk);
    tftChipSelect = 1'b0;
    m_pend = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic window(input int cmd, input int s, input int en);
    write_byte(0, cmd);
    write_byte(1, s >> 8); write_byte(1, s & 255);
    write_byte(1, en >> 8); write_byte(1, en & 255);
  endtask

  task automatic pixel(input int v);
    write_byte(1, v >> 8); write_byte(1, v & 255);
  endtask

  // Monitor: every strobe must match the head of the scoreboard
  always @(negedge clk) begin
    if (reset && (cmdStrobe || paramStrobe || pixelWrEn)) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe: cmd=%0b par=%0b pix=%0b addr=%0d, expected no strobe",
                 cmdStrobe, paramStrobe, pixelWrEn, pixelAddr);
      end else begin
        e = sb.pop_front();
        if (e.kind == 0 && !(cmdStrobe && !paramStrobe && !pixelWrEn && cmdByte == e.b)) begin
          errors++;
          $display("FAIL cmd: got stb=%0b/%0b/%0b byte=%02h, expected cmd %02h",
                   cmdStrobe, paramStrobe, pixelWrEn, cmdByte, e.b);
        end else if (e.kind == 1 && !(paramStrobe && !cmdStrobe && !pixelWrEn &&
                                      paramByte == e.b && paramIndex == e.idx)) begin
          errors++;
          $display("FAIL param: got stb=%0b/%0b/%0b byte=%02h idx=%0d, expected %02h idx=%0d",
                   cmdStrobe, paramStrobe, pixelWrEn, paramByte, paramIndex, e.b, e.idx);
        end else if (e.kind == 2 && !(pixelWrEn && !cmdStrobe && !paramStrobe &&
                                      pixelData == e.data && pixelAddr == e.addr &&
                                      frameDone == e.fd)) begin
          errors++;
          $display("FAIL pixel: got we=%0b data=%04h addr=%0d fd=%0b, expected %04h addr=%0d fd=%0b",
                   pixelWrEn, pixelData, pixelAddr, frameDone, e.data, e.addr, e.fd);
        end
      end
    end
    if (reset && frameDone && !pixelWrEn) begin
      checks++; errors++;
      $display("FAIL frame_done_alone: frameDone=1 with pixelWrEn=0, expected 0");
    end
  end

  initial begin
    int r, n;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_outputs", all_outs(), 64'h0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Single red pixel at the origin
    write_byte(0, 'h2C);
    pixel('hF800);
    chk("first_pixel_data", {48'h0, pixelData}, 64'hF800);
    chk("first_pixel_addr", {47'h0, pixelAddr}, 64'h0);

    // Strobe latency: WRX rises at a negedge; pulse follows the 4th posedge
    @(negedge clk);
    tftDataCmd = 1'b0; tftParallelPort = 8'h36; tftChipSelect = 1'b0; tftWriteEnable = 1'b0;
    repeat (3) @(negedge clk);
    tftWriteEnable = 1'b1;
    model_byte(0, 'h36);
    repeat (3) @(posedge clk);
    #1 chk("latency_not_early", {63'h0, cmdStrobe}, 64'h0);
    @(posedge clk);
    #1 chk("latency_on_time", {55'h0, cmdStrobe, cmdByte}, {55'h0, 1'b1, 8'h36});
    repeat (3) @(negedge clk);
    write_byte(1, 'h48);
    chk("param_byte_idx", {49'h0, paramByte, paramIndex}, {49'h0, 8'h48, 7'd0});

    // Window 10..11 x 5..6: wrap at column end, frame end, then wrap to start
    window('h2A, 10, 11);
    window('h2B, 5, 6);
    write_byte(0, 'h2C);
    for (int i = 0; i < 4; i++) pixel($urandom_range(0, 65535));
    chk("window_last_addr", {47'h0, pixelAddr}, 64'd1451);
    pixel('h0F0F);
    chk("window_wrap_addr", {47'h0, pixelAddr}, 64'd1210);

    // Host display reset; a byte written while it is low is dropped
    @(negedge clk);
    tftReset = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    write_byte(0, 'h2A);
    chk("host_reset_clears", all_outs(), 64'h0);
    tftReset = 1'b1;
    repeat (4) @(negedge clk);

    // Reversed column window is discarded
    window('h2A, 20, 10);
    write_byte(0, 'h2C);
    pixel('h1111);
    chk("bad_window_addr", {47'h0, pixelAddr}, 64'd0);
    pixel('h2222);
    chk("bad_window_next", {47'h0, pixelAddr}, 64'd1);

    // CSX toggle mid-pixel drops the high byte
    write_byte(0, 'h2C);
    write_byte(1, 'hAB);
    cs_toggle();
    pixel('h1234);
    chk("cs_toggle_pixel", {48'h0, pixelData}, 64'h1234);
    write_byte(1, 'h56);
    write_byte(0, 'h2C);
    pixel('h789A);
    chk("cmd_mid_pixel", {48'h0, pixelData}, 64'h789A);

    // Asynchronous reset in the middle of a pixel stream
    write_byte(1, 'hCD);
    #2 reset = 1'b0;
    #1 chk("async_reset_outputs", all_outs(), 64'h0);
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    write_byte(1, 'h11); write_byte(1, 'h22);
    write_byte(0, 'h2C);
    pixel('hBEEF);
    chk("post_reset_pixel", {31'h0, pixelAddr, pixelData}, {31'h0, 17'd0, 16'hBEEF});

    // Random traffic against the model
    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0: window('h2A, (($urandom_range(0, 7) == 0) ? 256 : 0) + $urandom_range(0, 255),
                  (($urandom_range(0, 7) == 0) ? 256 : 0) + $urandom_range(0, 255));
        1: window('h2B, $urandom_range(0, 330), $urandom_range(0, 330));
        2: write_byte(0, 'h2C);
        3: write_byte(0, 'h3C);
        4: begin
          n = $urandom_range(0, 255);
          if (n == 'h2A || n == 'h2B || n == 'h2C || n == 'h3C) n = 'h36;
          write_byte(0, n);
          for (int k = 0; k < int'($urandom_range(0, 3)); k++) write_byte(1, $urandom_range(0, 255));
        end
        5: cs_toggle();
        default: write_byte(1, $urandom_range(0, 255));
      endcase
    end

    n = 0;
    while (sb.size() != 0 && n < 50) begin @(negedge clk); n++; end
    chk("scoreboard_drained", 64'(sb.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
